// File: rtl/bludge_penalty_scheduler_if.sv
// Bus between the penalty scheduler, the bludger controllers and the movement/score logic.
// The scheduler is the master and drives everything except bludged and event_ready.
interface bludge_penalty_scheduler_if;
  logic [3:0] bludged;
  logic [3:0] clean;
  logic [3:0] frozen;
  logic       event_valid;
  logic [1:0] event_player;
  logic       event_ready;
  logic       event_overflow;

  modport master (
    input  bludged, event_ready,
    output clean, frozen, event_valid, event_player, event_overflow
  );

  modport slave (
    output bludged, event_ready,
    input  clean, frozen, event_valid, event_player, event_overflow
  );
endinterface

// File: rtl/bludge_penalty_scheduler.sv
// Penalty lifecycle for the four bludged players: freeze, flag-clear handshake, immunity,
// plus a round-robin arbiter serialising penalty events onto one valid/ready channel.
module bludge_penalty_scheduler #(
  parameter int FREEZE_TICKS = 60,
  parameter int IMMUNE_TICKS = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          game_initiated,
  input  logic                          tick,
  bludge_penalty_scheduler_if.master    bus,
  output logic [7:0]                    dbg_state
);

  localparam int MAX_TICKS = (FREEZE_TICKS > IMMUNE_TICKS) ? FREEZE_TICKS : IMMUNE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FROZEN, CLEAR, IMMUNE} state_t;

  state_t          st  [4];
  logic [CW-1:0]   cnt [4];
  logic            game_active;
  logic [3:0]      frozen_r, clean_r;
  logic [3:0]      pending, set_vec, clr_vec, pend_nxt;
  logic [1:0]      rr_ptr, rr_nxt, player_r;
  logic            overflow_r, event_valid_w, accept;

  // Search order starts one past ptr; the nearest requester wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < 4; i++)
      set_vec[i] = game_active && (st[i] == IDLE) && bus.bludged[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_active <= 1'b0;
      frozen_r    <= '0;
      clean_r     <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      if (game_initiated) game_active <= 1'b1;
      if (!game_active) begin
        // Scrub stale flags until the game starts; drop the scrub on the arming edge.
        frozen_r <= '0;
        clean_r  <= game_initiated ? 4'h0 : 4'hF;
        for (int i = 0; i < 4; i++) begin
          st[i]  <= IDLE;
          cnt[i] <= '0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          case (st[i])
            IDLE: if (bus.bludged[i]) begin
              st[i]       <= FROZEN;
              cnt[i]      <= CW'(FREEZE_TICKS);
              frozen_r[i] <= 1'b1;
              clean_r[i]  <= 1'b0;
            end
            FROZEN: if (tick) begin
              if (cnt[i] <= CW'(1)) begin
                st[i]      <= CLEAR;
                clean_r[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
            CLEAR: if (!bus.bludged[i]) begin
              st[i]       <= IMMUNE;
              cnt[i]      <= CW'(IMMUNE_TICKS);
              frozen_r[i] <= 1'b0;
            end
            IMMUNE: if (tick) begin
              if (cnt[i] <= CW'(1)) begin
                st[i]      <= IDLE;
                clean_r[i] <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
            default: st[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Event channel: a transfer happens on a clk edge where event_valid and event_ready are
  // both 1; while valid is held without ready, event_player is frozen and cannot be preempted.
  assign event_valid_w = |pending;
  assign accept        = event_valid_w && bus.event_ready;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[player_r] = 1'b1;
    pend_nxt = (pending & ~clr_vec) | set_vec;
    rr_nxt   = accept ? player_r : rr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= 2'd3;
      player_r   <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      pending <= pend_nxt;
      rr_ptr  <= rr_nxt;
      // A hit on a player whose event is still pending (even one retiring now) coalesces.
      if (|(set_vec & pending)) overflow_r <= 1'b1;
      if (!(event_valid_w && !bus.event_ready) && (|pend_nxt))
        player_r <= rr_pick(pend_nxt, rr_nxt);
    end
  end

  assign bus.clean          = clean_r;
  assign bus.frozen         = frozen_r;
  assign bus.event_valid    = event_valid_w;
  assign bus.event_player   = player_r;
  assign bus.event_overflow = overflow_r;
  assign dbg_state          = {st[3], st[2], st[1], st[0]};

endmodule

// File: tb/tb_bludge_penalty_scheduler.sv
// Directed bench for bludge_penalty_scheduler with FREEZE_TICKS=3, IMMUNE_TICKS=2.
// Inputs change 1ns after posedge; outputs are checked there and events scored at negedge.
module tb_bludge_penalty_scheduler;
  logic       clk;
  logic       rst_n;
  logic       game_initiated;
  logic       tick;
  logic [7:0] dbg_state;
  int         n_vec;
  int         n_miss;
  logic [1:0] exp_q[$];

  bludge_penalty_scheduler_if bus();

  bludge_penalty_scheduler #(.FREEZE_TICKS(3), .IMMUNE_TICKS(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_initiated (game_initiated),
    .tick           (tick),
    .bus            (bus),
    .dbg_state      (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
  endtask

  task automatic tick4();
    repeat (3) clk_step();
    do_tick();
  endtask

  // scoreboard: every accepted event must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && bus.event_valid && bus.event_ready) begin
      if (exp_q.size() == 0) check("evt_extra", {30'd0, bus.event_player}, 32'hFFFF_FFFF);
      else                   check("evt_order", {30'd0, bus.event_player}, {30'd0, exp_q.pop_front()});
    end
  end

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    game_initiated = 1'b0;
    tick           = 1'b0;
    bus.bludged    = 4'h0;
    bus.event_ready = 1'b0;
    repeat (2) clk_step();
    check("rst_clean",  bus.clean, 4'h0);
    check("rst_frozen", bus.frozen, 4'h0);
    check("rst_valid",  bus.event_valid, 1'b0);
    check("rst_ovf",    bus.event_overflow, 1'b0);
    rst_n = 1'b1;

    // pre-start: flags ignored and scrubbed
    bus.bludged = 4'hF;
    clk_step();
    check("pre_clean",  bus.clean, 4'hF);
    check("pre_frozen", bus.frozen, 4'h0);
    clk_step();
    check("pre_valid",  bus.event_valid, 1'b0);
    bus.bludged = 4'h0;
    game_initiated = 1'b1;
    clk_step();
    game_initiated = 1'b0;
    check("start_clean", bus.clean, 4'h0);

    // arbitration: 0,1,3 from rr_ptr=3
    bus.event_ready = 1'b1;
    bus.bludged = 4'b1011;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    clk_step();
    bus.bludged = 4'h0;
    check("arb_frozen", bus.frozen, 4'b1011);
    check("arb_first",  bus.event_player, 2'd0);
    repeat (3) clk_step();
    check("arb_drain",  bus.event_valid, 1'b0);
    repeat (6) tick4();
    check("arb_idle_frz", bus.frozen, 4'h0);
    check("arb_idle_cln", bus.clean, 4'h0);

    // backpressure: grant 0 held 10 cycles, then 0 then 2
    bus.event_ready = 1'b0;
    bus.bludged = 4'b0101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    clk_step();
    bus.bludged = 4'h0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid",  bus.event_valid, 1'b1);
      check("bp_player", bus.event_player, 2'd0);
      clk_step();
    end
    bus.event_ready = 1'b1;
    clk_step();
    check("bp_second", bus.event_player, 2'd2);
    check("bp_valid2", bus.event_valid, 1'b1);
    clk_step();
    check("bp_drain",  bus.event_valid, 1'b0);
    repeat (6) tick4();

    // freeze/release on player 1
    bus.bludged = 4'b0010;
    exp_q.push_back(2'd1);
    clk_step();
    check("frz_frozen", bus.frozen, 4'b0010);
    tick4();
    tick4();
    check("frz_tick2_cln", bus.clean, 4'h0);
    tick4();
    check("frz_clean",  bus.clean, 4'b0010);
    check("frz_hold",   bus.frozen, 4'b0010);
    repeat (5) clk_step();
    check("frz_stuck",  bus.frozen, 4'b0010);
    bus.bludged = 4'h0;
    clk_step();
    check("rel_frozen", bus.frozen, 4'h0);
    check("rel_clean",  bus.clean, 4'b0010);

    // immunity: re-hit ignored
    bus.bludged = 4'b0010;
    tick4();
    check("imm_frozen", bus.frozen, 4'h0);
    check("imm_clean",  bus.clean, 4'b0010);
    check("imm_valid",  bus.event_valid, 1'b0);
    bus.bludged = 4'h0;
    repeat (3) clk_step();
    check("imm_clean2", bus.clean, 4'b0010);
    do_tick();
    check("imm_end_cln", bus.clean, 4'h0);
    check("imm_end_frz", bus.frozen, 4'h0);

    // overflow on player 2 under backpressure
    bus.event_ready = 1'b0;
    bus.bludged = 4'b0100;
    exp_q.push_back(2'd2);
    clk_step();
    check("ovf_player", bus.event_player, 2'd2);
    repeat (3) tick4();
    check("ovf_clean", bus.clean, 4'b0100);
    bus.bludged = 4'h0;
    clk_step();
    repeat (2) tick4();
    check("ovf_idle",  bus.clean, 4'h0);
    check("ovf_none",  bus.event_overflow, 1'b0);
    bus.bludged = 4'b0100;
    clk_step();
    check("ovf_set",    bus.event_overflow, 1'b1);
    check("ovf_frozen", bus.frozen, 4'b0100);
    check("ovf_valid",  bus.event_valid, 1'b1);
    bus.event_ready = 1'b1;
    clk_step();
    repeat (2) clk_step();
    check("ovf_single", bus.event_valid, 1'b0);
    check("ovf_sticky", bus.event_overflow, 1'b1);
    check("sb_empty",   exp_q.size(), 32'd0);

    // async reset mid-FROZEN, no clock edge
    check("pre_rst_frz", bus.frozen, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_frozen", bus.frozen, 4'h0);
    check("arst_clean",  bus.clean, 4'h0);
    check("arst_valid",  bus.event_valid, 1'b0);
    check("arst_ovf",    bus.event_overflow, 1'b0);
    check("arst_state",  dbg_state, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
